// File: rtl/timer_responder.sv
// timer_responder: DMG timer block (DIV, TIMA, TMA, TAC) as a system-bus target.
// DIV sits at BASE_ADDR. TIMA, TMA and TAC follow at BASE_ADDR+1..+3.
// Build option: define TIMER_DIV_GLITCH_EN so that write-induced falling edges
// of the muxed tick signal also increment TIMA. With the macro undefined, only
// natural divider counting increments TIMA.
`timescale 1ns/1ps
module timer_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] bus_addr,
  input  logic        bus_enable,
  input  logic        bus_write,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_selected,
  output logic        irq_timer
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_RELOAD  = 2'd2
  } ovf_state_e;

  // Architectural state.
  logic [15:0] div_q,  div_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q,  tma_d;
  logic [2:0]  tac_q,  tac_d;
  logic        tick_q, tick_d;
  ovf_state_e  state_q, state_d;
  logic [1:0]  cnt_q,  cnt_d;
  logic        irq_q,  irq_d;

  // Decode and tick-source signals.
  logic [15:0] offset;
  logic        hit;
  logic [1:0]  reg_idx;
  logic        wr_commit;
  logic        div_wr, tima_wr, tma_wr, tac_wr;
  logic        tick_sig;
  logic        tick_inc;

  // Picks the divider tap that clocks TIMA for a given TAC rate selection.
  function automatic logic tick_tap(input logic [15:0] div, input logic [1:0] rate);
    case (rate)
      2'b00:   tick_tap = div[9];
      2'b01:   tick_tap = div[3];
      2'b10:   tick_tap = div[5];
      default: tick_tap = div[7];
    endcase
  endfunction

  assign offset    = bus_addr - BASE_ADDR;
  assign hit       = (offset[15:2] == 14'd0);
  assign reg_idx   = offset[1:0];
  assign wr_commit = bus_enable & bus_write & hit & (t_cycle == 2'd3);
  assign div_wr    = wr_commit & (reg_idx == 2'd0);
  assign tima_wr   = wr_commit & (reg_idx == 2'd1);
  assign tma_wr    = wr_commit & (reg_idx == 2'd2);
  assign tac_wr    = wr_commit & (reg_idx == 2'd3);

  assign tick_sig  = tac_q[2] & tick_tap(div_q, tac_q[1:0]);
  assign irq_timer = irq_q;

`ifdef TIMER_DIV_GLITCH_EN
  // Any 1->0 of the muxed tick signal counts, including ones caused by writes.
  assign tick_inc = tick_q & ~tick_sig;
`else
  logic count_only_q, count_only_d;

  // Marks edges where the tick source moved only because div counted on its own.
  always_comb begin
    count_only_d = ~div_wr & ~(tac_wr & (bus_data_in[2:0] != tac_q));
  end

  // Register the natural-counting marker alongside tick_q.
  always_ff @(posedge clk) begin
    if (reset) count_only_q <= 1'b0;
    else       count_only_q <= count_only_d;
  end

  assign tick_inc = tick_q & ~tick_sig & count_only_q;
`endif

  // State register: all timer state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= 16'h0000;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      tick_q  <= 1'b0;
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      irq_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state: divider, register writes, TIMA counting and the overflow sequencer.
  always_comb begin
    div_d   = div_q + 16'd1;
    tima_d  = tima_q;
    tma_d   = tma_q;
    tac_d   = tac_q;
    tick_d  = tick_sig;
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;

    // A DIV write clears the divider even on an edge where it would count.
    if (div_wr) div_d = 16'h0000;
    if (tma_wr) tma_d = bus_data_in;
    if (tac_wr) tac_d = bus_data_in[2:0];

    case (state_q)
      ST_RUN: begin
        if (tima_wr) begin
          tima_d = bus_data_in;
        end else if (tick_inc) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_PENDING;
            cnt_d   = 2'd3;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end

      ST_PENDING: begin
        if (tima_wr) begin
          // A CPU write during the delay abandons the reload and the interrupt.
          tima_d  = bus_data_in;
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else if (cnt_q == 2'd0) begin
          // tma_d so a TMA write on this very edge is what gets reloaded.
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = ST_RELOAD;
          cnt_d   = 2'd3;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (tick_inc) tima_d = tima_q + 8'd1;
        end
      end

      ST_RELOAD: begin
        if (cnt_q == 2'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 2'd1;
        // TIMA writes are dropped here; a TMA write lands in both registers.
        if (tma_wr) begin
          tima_d = bus_data_in;
        end else if (tick_inc) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = ST_PENDING;
            cnt_d   = 2'd3;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output: combinational read mux, idle bus value 8'hFF.
  always_comb begin
    bus_selected = 1'b0;
    bus_data_out = 8'hFF;
    if (!reset && bus_enable && hit) begin
      bus_selected = 1'b1;
      case (reg_idx)
        2'd0:    bus_data_out = div_q[15:8];
        2'd1:    bus_data_out = tima_q;
        2'd2:    bus_data_out = tma_q;
        default: bus_data_out = {5'b11111, tac_q};
      endcase
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// tb_timer_responder: directed stimulus with a read scoreboard for timer_responder.
`timescale 1ns/1ps
module tb_timer_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_enable = 1'b0;
  logic        bus_write = 1'b0;
  logic [7:0]  bus_data_in = 8'h00;
  logic [7:0]  bus_data_out;
  logic        bus_selected;
  logic        irq_timer;

  timer_responder dut (
    .clk          (clk),
    .reset        (reset),
    .t_cycle      (t_cycle),
    .bus_addr     (bus_addr),
    .bus_enable   (bus_enable),
    .bus_write    (bus_write),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_selected (bus_selected),
    .irq_timer    (irq_timer)
  );

  always #5 clk = ~clk;

`ifdef TIMER_DIV_GLITCH_EN
  localparam logic [7:0] TIMA_AFTER_DIV_WR = 8'h34;
`else
  localparam logic [7:0] TIMA_AFTER_DIV_WR = 8'h33;
`endif

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        sel;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   irq_seen = 0;
  int   rd_id = 0;
  int   cyc = 0;

  // Monitor: pops one expectation for every read cycle the stimulus flags.
  always @(negedge clk) begin
    exp_t e;
    if (irq_timer === 1'b1) irq_seen++;
    if (chk) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: read seen with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (bus_data_out !== e.data || bus_selected !== e.sel || irq_timer !== e.irq) begin
          n_bad++;
          $display("FAIL rd%0d addr=%h: got data=%h sel=%b irq=%b, want data=%h sel=%b irq=%b",
                   e.id, e.addr, bus_data_out, bus_selected, irq_timer, e.data, e.sel, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic s, input logic i);
    exp_t e;
    e.id   = rd_id[15:0];
    e.addr = a;
    e.data = d;
    e.sel  = s;
    e.irq  = i;
    exp_q.push_back(e);
    rd_id++;
    bus_addr   = a;
    bus_enable = 1'b1;
    bus_write  = 1'b0;
    chk        = 1'b1;
    step();
    chk        = 1'b0;
    bus_enable = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [1:0] t);
    bus_addr    = a;
    bus_data_in = d;
    bus_enable  = 1'b1;
    bus_write   = 1'b1;
    t_cycle     = t;
    step();
    bus_enable  = 1'b0;
    bus_write   = 1'b0;
    t_cycle     = 2'd0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reads while reset is held see the idle bus.
    rd(16'hFF05, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;

    // Reset values and decode boundaries.
    rd(16'hFF04, 8'h00, 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    rd(16'hFF06, 8'h00, 1'b1, 1'b0);
    rd(16'hFF07, 8'hF8, 1'b1, 1'b0);
    rd(16'hFF08, 8'hFF, 1'b0, 1'b0);
    rd(16'hFF03, 8'hFF, 1'b0, 1'b0);

    // Divider: div = 1030 here, DIV = 04. Writes only commit at t_cycle 3.
    repeat (1024) step();
    rd(16'hFF04, 8'h04, 1'b1, 1'b0);
    wr(16'hFF04, 8'hAB, 2'd2);
    rd(16'hFF04, 8'h04, 1'b1, 1'b0);
    wr(16'hFF04, 8'hAB, 2'd3);
    rd(16'hFF04, 8'h00, 1'b1, 1'b0);

    // Overflow and reload. cyc n means div = n; div[3] falls at 16, 32, 48, 64.
    wr(16'hFF04, 8'h00, 2'd3);
    cyc = 0;
    wr(16'hFF07, 8'hF5, 2'd3);
    wr(16'hFF06, 8'h80, 2'd3);
    wr(16'hFF05, 8'hFE, 2'd3);
    rd(16'hFF07, 8'hFD, 1'b1, 1'b0);
    rd(16'hFF06, 8'h80, 1'b1, 1'b0);
    idle_until(16);
    rd(16'hFF05, 8'hFE, 1'b1, 1'b0);
    rd(16'hFF05, 8'hFF, 1'b1, 1'b0);
    idle_until(33);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    rd(16'hFF05, 8'h80, 1'b1, 1'b1);
    wr(16'hFF05, 8'h55, 2'd3);
    rd(16'hFF05, 8'h80, 1'b1, 1'b0);
    wr(16'hFF06, 8'h44, 2'd3);
    rd(16'hFF05, 8'h44, 1'b1, 1'b0);
    rd(16'hFF06, 8'h44, 1'b1, 1'b0);
    idle_until(49);
    rd(16'hFF05, 8'h45, 1'b1, 1'b0);
    idle_until(64);
    wr(16'hFF05, 8'h10, 2'd3);
    rd(16'hFF05, 8'h10, 1'b1, 1'b0);

    // TIMA write during the pending window cancels reload and interrupt.
    wr(16'hFF04, 8'h00, 2'd3);
    cyc = 0;
    wr(16'hFF05, 8'hFE, 2'd3);
    idle_until(17);
    rd(16'hFF05, 8'hFF, 1'b1, 1'b0);
    idle_until(33);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    wr(16'hFF05, 8'h33, 2'd3);
    rd(16'hFF05, 8'h33, 1'b1, 1'b0);
    idle_until(40);
    rd(16'hFF05, 8'h33, 1'b1, 1'b0);

    // DIV write while the selected tap (div[3]) is high.
    idle_until(42);
    wr(16'hFF04, 8'h00, 2'd3);
    cyc = 0;
    rd(16'hFF05, 8'h33, 1'b1, 1'b0);
    rd(16'hFF05, TIMA_AFTER_DIV_WR, 1'b1, 1'b0);
    rd(16'hFF05, TIMA_AFTER_DIV_WR, 1'b1, 1'b0);

    // Reset asserted inside the pending window: no interrupt, reset values back.
    wr(16'hFF05, 8'hFF, 2'd3);
    idle_until(18);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    reset = 1'b1;
    rd(16'hFF05, 8'hFF, 1'b0, 1'b0);
    rd(16'hFF04, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    rd(16'hFF04, 8'h00, 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);
    rd(16'hFF06, 8'h00, 1'b1, 1'b0);
    rd(16'hFF07, 8'hF8, 1'b1, 1'b0);
    repeat (10) step();
    rd(16'hFF05, 8'h00, 1'b1, 1'b0);

    repeat (2) step();
    n_cmp++;
    if (irq_seen != 1) begin
      n_bad++;
      $display("FAIL irq_pulse_count: got %0d pulses, want 1", irq_seen);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
